// File: rtl/tx_bridge_pkg.sv
// Shared state encoding, port count and default timing values for the TX frame arbiter.
package tx_bridge_pkg;

  localparam int          NUM_PORTS   = 2;
  localparam logic [15:0] DEF_MIN_LEN = 16'd64;
  localparam int          DEF_IFG     = 12;
  localparam logic [15:0] DEF_WDOG    = 16'd4095;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    port_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the pointer remembers the last serviced/rejected port.
// Build option TX_ARB_FIXED_PRIO_EN: port0 always wins and the pointer is ignored.
module rr_arb2
  import tx_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 adv,
  output logic                 win
);

  logic last_q;

  // Reset points at port1 so that port0 is favoured on the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (adv) begin
      last_q <= win;
    end
  end

`ifdef TX_ARB_FIXED_PRIO_EN
  always_comb begin
    win = ~req[0];
  end
`else
  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last_q;
    end
  end
`endif

endmodule

// File: rtl/tx_frame_arbiter.sv
// Arbitrates two frame buffers onto one TX datapath with length check, IFG and watchdog.
// Build option TX_ARB_FIXED_PRIO_EN selects fixed port0 priority inside rr_arb2.
module tx_frame_arbiter
  import tx_bridge_pkg::*;
#(
  parameter logic [15:0] MIN_LEN = DEF_MIN_LEN,
  parameter int          IFG     = DEF_IFG,
  parameter logic [15:0] WDOG    = DEF_WDOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [15:0]          len0,
  input  logic [15:0]          len1,
  input  logic [7:0]           data0,
  input  logic [7:0]           data1,
  output logic [NUM_PORTS-1:0] pop,
  output logic [15:0]          frm_len,
  output logic [7:0]           tx_data,
  output logic                 empty_buff,
  input  logic                 nextByte,
  input  logic                 last_byte,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [NUM_PORTS-1:0] gnt_pulse,
  output logic [NUM_PORTS-1:0] rej_pulse,
  output logic                 wdog_err
);

  localparam logic [15:0] IFG_LOAD = 16'(IFG - 1);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [15:0]          frm_len_d;
  logic [15:0]          ifg_cnt_q, ifg_cnt_d;
  logic [15:0]          wdog_cnt_q, wdog_cnt_d;
  logic [NUM_PORTS-1:0] gnt_pulse_d, rej_pulse_d;
  logic                 wdog_err_d;
  logic                 armed_q;
  logic                 arb_adv;
  logic                 arb_win;
  logic [15:0]          sel_len;

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (arb_adv),
    .win (arb_win)
  );

  assign sel_len = arb_win ? len1 : len0;

  // armed_q holds off arbitration for one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      frm_len    <= 16'd0;
      ifg_cnt_q  <= 16'd0;
      wdog_cnt_q <= 16'd0;
      gnt_pulse  <= '0;
      rej_pulse  <= '0;
      wdog_err   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      frm_len    <= frm_len_d;
      ifg_cnt_q  <= ifg_cnt_d;
      wdog_cnt_q <= wdog_cnt_d;
      gnt_pulse  <= gnt_pulse_d;
      rej_pulse  <= rej_pulse_d;
      wdog_err   <= wdog_err_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    frm_len_d   = frm_len;
    ifg_cnt_d   = ifg_cnt_q;
    wdog_cnt_d  = wdog_cnt_q;
    gnt_pulse_d = '0;
    rej_pulse_d = '0;
    wdog_err_d  = 1'b0;
    arb_adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && (req != '0)) begin
          arb_adv = 1'b1;
          if (sel_len >= MIN_LEN) begin
            owner_d     = arb_win;
            frm_len_d   = sel_len;
            gnt_pulse_d = port_onehot(arb_win);
            wdog_cnt_d  = 16'd0;
            state_d     = XFER;
          end else begin
            rej_pulse_d = port_onehot(arb_win);
          end
        end
      end

      // A last_byte coinciding with watchdog expiry is treated as a clean end.
      XFER: begin
        wdog_cnt_d = wdog_cnt_q + 16'd1;
        if (last_byte) begin
          state_d   = GAP;
          ifg_cnt_d = IFG_LOAD;
        end else if (wdog_cnt_q == (WDOG - 16'd1)) begin
          state_d    = GAP;
          ifg_cnt_d  = IFG_LOAD;
          wdog_err_d = 1'b1;
        end
      end

      GAP: begin
        if (ifg_cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt        = '0;
    pop        = '0;
    tx_data    = 8'h00;
    empty_buff = 1'b1;
    if (state_q == XFER) begin
      gnt        = port_onehot(owner_q);
      pop        = nextByte ? port_onehot(owner_q) : '0;
      tx_data    = owner_q ? data1 : data0;
      empty_buff = 1'b0;
    end
  end

endmodule
